// File: rtl/fc_layer_engine.sv
// fc_layer_engine: fully connected layer; LANES parallel MACs over an IFM_DEPTH input vector, streaming NUM_NEURONS results
module fc_layer_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_WIDTH = 40,
  parameter int IFM_DEPTH = 120,
  parameter int NUM_NEURONS = 84,
  parameter int LANES = 4,
  localparam int GROUPS = (NUM_NEURONS + LANES - 1) / LANES,
  localparam int WADDR = $clog2(GROUPS * IFM_DEPTH),
  localparam int NW = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      wm_we,
  input  logic [WADDR-1:0]      wm_addr,
  input  logic [DATA_WIDTH-1:0] wm_data,
  input  logic                  bm_we,
  input  logic [NW-1:0]         bm_addr,
  input  logic [DATA_WIDTH-1:0] bm_data,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NW-1:0]         out_index,
  output logic                  out_last
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int CW = $clog2(IFM_DEPTH + 2);
  localparam int IW = IFM_DEPTH > 1 ? $clog2(IFM_DEPTH) : 1;
  localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic signed [AW-1:0] MAXV = AW'({(DW-1){1'b1}});
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;
  state_t state, nxt;

  logic [CW-1:0] cnt;
  logic [GW-1:0] group;
  logic [LW-1:0] lane;
  logic relu_q, rv, hs, grp_end, enter_c;
  logic [WADDR-1:0] raddr;
  logic [DW-1:0] wmem [LANES][GROUPS*IFM_DEPTH];
  logic [DW-1:0] bmem [NUM_NEURONS];
  logic [DW-1:0] ifm [IFM_DEPTH];
  logic signed [DW-1:0] w_q [LANES];
  logic signed [DW-1:0] x_q;
  logic signed [AW-1:0] acc [LANES];
  logic signed [DW-1:0] bias [LANES];
  logic signed [AW-1:0] sh [LANES];
  logic [DW-1:0] res_n [LANES];
  logic [DW-1:0] res [LANES];

  assign busy = state != IDLE;
  assign done = state == DONE;
  assign in_ready = state == LOAD;
  assign out_valid = state == DRAIN;
  assign out_index = out_valid ? NW'(int'(group) * LANES + int'(lane)) : '0;
  assign out_data = out_valid ? res[lane] : '0;
  assign out_last = out_valid && out_index == NW'(NUM_NEURONS - 1);
  assign hs = out_valid && out_ready;
  assign grp_end = lane == LW'(LANES - 1) || out_last;
  assign enter_c = nxt == COMPUTE && state != COMPUTE;
  assign raddr = WADDR'(int'(group) * IFM_DEPTH + int'(cnt));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = in_valid && cnt == CW'(IFM_DEPTH - 1) ? COMPUTE : LOAD;
      COMPUTE: nxt = cnt == CW'(IFM_DEPTH + 1) ? DRAIN : COMPUTE;
      DRAIN:   nxt = !(hs && grp_end) ? DRAIN : group == GW'(GROUPS - 1) ? DONE : COMPUTE;
      default: nxt = IDLE;
    endcase
  end

  // bias, rescale, saturate, optional ReLU on the finished accumulators
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      bias[l] = int'(group) * LANES + l < NUM_NEURONS ? bmem[NW'(int'(group) * LANES + l)] : '0;
      sh[l] = (acc[l] + (AW'(bias[l]) <<< FRAC_BITS)) >>> FRAC_BITS;
      res_n[l] = sh[l] > MAXV ? MAXV[DW-1:0] : sh[l] < MINV ? MINV[DW-1:0] : sh[l][DW-1:0];
      res_n[l] = relu_q && res_n[l][DW-1] ? '0 : res_n[l];
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      group <= '0;
      lane <= '0;
      relu_q <= 1'b0;
      rv <= 1'b0;
      acc <= '{default: '0};
      res <= '{default: '0};
    end else begin
      rv <= state == COMPUTE && cnt < CW'(IFM_DEPTH);
      if (state == IDLE && start) begin
        relu_q <= relu_en;
        group <= '0;
        cnt <= '0;
      end
      if ((state == LOAD && in_valid) || state == COMPUTE) cnt <= cnt + CW'(1);
      for (int l = 0; l < LANES; l++)
        if (rv) acc[l] <= acc[l] + AW'(w_q[l]) * AW'(x_q);
      if (state == COMPUTE && nxt == DRAIN) begin
        res <= res_n;
        lane <= '0;
      end
      if (hs) lane <= lane + LW'(1);
      if (hs && grp_end && nxt == COMPUTE) group <= group + GW'(1);
      if (enter_c) begin
        cnt <= '0;
        acc <= '{default: '0};
      end
    end
  end

  // storage is deliberately unreset so weights survive an aborted run
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (state == IDLE && wm_we[l]) wmem[l][wm_addr] <= wm_data;
      w_q[l] <= wmem[l][raddr];
    end
    if (state == IDLE && bm_we) bmem[bm_addr] <= bm_data;
    if (state == LOAD && in_valid) ifm[IW'(cnt)] <= in_data;
    x_q <= ifm[IW'(cnt)];
  end
endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: scoreboarded random and directed runs against an arithmetic model of the layer
module tb_fc_layer_engine;
  logic clk = 0, reset = 0;
  logic [3:0] wm_we = 0;
  logic [2:0] wm_addr = 0, bm_addr = 0, out_index;
  logic [15:0] wm_data = 0, bm_data = 0, in_data = 0, out_data;
  logic bm_we = 0, start = 0, relu_en = 0, in_valid = 0, out_ready = 1;
  logic busy, done, in_ready, out_valid, out_last;

  fc_layer_engine #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .IFM_DEPTH(4), .NUM_NEURONS(6), .LANES(4)) dut (
    .clk(clk), .reset(reset), .wm_we(wm_we), .wm_addr(wm_addr), .wm_data(wm_data),
    .bm_we(bm_we), .bm_addr(bm_addr), .bm_data(bm_data), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index), .out_last(out_last));

  always #5 clk = ~clk;

  typedef struct {logic [2:0] idx; logic [15:0] data; logic last;} exp_t;
  exp_t q[$];
  exp_t e;
  shortint W[6][4];
  shortint B[6];
  shortint X[4];
  logic [15:0] got[6];
  logic [15:0] ident[6] = '{16'h0100, 16'h0200, 16'h0300, 16'hFC00, 16'h0100, 16'h0200};
  int checks = 0, errors = 0, done_cnt = 0, stall = 0, bp_mode = 0;
  logic pv = 0, pr = 0, pl = 0;
  logic [15:0] pd = 0;
  logic [2:0] pi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(int n, bit relu);
    longint a = 0;
    for (int i = 0; i < 4; i++) a += longint'(W[n][i]) * longint'(X[i]);
    a = (a + longint'(B[n]) * 256) >>> 8;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    if (relu && a < 0) a = 0;
    return 16'(a);
  endfunction

  always @(negedge clk) begin
    if (pv && !pr && reset) begin
      checks++;
      if (!(out_valid && out_data == pd && out_index == pi && out_last == pl)) begin
        errors++;
        $display("FAIL hold: got v=%0b d=%h i=%0d l=%0b expected v=1 d=%h i=%0d l=%0b",
                 out_valid, out_data, out_index, out_last, pd, pi, pl);
      end
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra output: got index %0d expected no output", out_index);
      end else begin
        e = q.pop_front();
        chk("out_index", 32'(out_index), 32'(e.idx));
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
      got[out_index] = out_data;
    end
    if (done) done_cnt++;
    pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode == 1 && out_valid && out_index == 2 && stall < 5) begin
      out_ready = 0;
      stall++;
    end else if (bp_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(int n, int i, logic [15:0] v);
    wm_we = 4'(1 << (n % 4)); wm_addr = 3'((n / 4) * 4 + i); wm_data = v;
    tick;
    wm_we = 0;
    W[n][i] = shortint'(v);
  endtask

  task automatic set_b(int n, logic [15:0] v);
    bm_we = 1; bm_addr = 3'(n); bm_data = v;
    tick;
    bm_we = 0;
    B[n] = shortint'(v);
  endtask

  task automatic feed(bit gaps);
    int k = 0, g = 0;
    bit a;
    while (k < 4 && g < 200) begin
      in_valid = !(gaps && $urandom_range(0, 2) == 0);
      in_data = X[k];
      @(negedge clk);
      a = in_valid && in_ready;
      tick;
      if (a) k++;
      g++;
    end
    in_valid = 0;
    chk("inputs accepted", k, 4);
  endtask

  task automatic run(bit relu, bit gaps, bit inject);
    int lat = 0, g = 0, d0;
    for (int n = 0; n < 6; n++) begin
      q.push_back('{3'(n), model(n, relu), n == 5});
      got[n] = 16'hDEAD;
    end
    d0 = done_cnt;
    stall = 0;
    start = 1; relu_en = relu;
    tick;
    start = 0; relu_en = 0;
    feed(gaps);
    while (!out_valid && lat < 50) begin
      if (inject && lat == 2) begin
        start = 1; wm_we = 4'b0001; wm_addr = 0; wm_data = 16'h1234;
        bm_we = 1; bm_addr = 0; bm_data = 16'h7777;
      end
      tick;
      start = 0; wm_we = 0; bm_we = 0;
      lat++;
    end
    chk("first out_valid latency", lat, 6);
    while (busy && g < 1000) begin
      tick;
      g++;
    end
    chk("run completes", 32'(busy), 0);
    chk("done pulses", done_cnt - d0, 1);
    chk("scoreboard drained", q.size(), 0);
    q.delete();
  endtask

  task automatic load_identity;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) set_w(n, i, i == n % 4 ? 16'h0100 : 16'h0000);
      set_b(n, 16'h0000);
    end
    X = '{16'h0100, 16'h0200, 16'h0300, 16'hFC00};
  endtask

  task automatic chk_identity;
    for (int n = 0; n < 6; n++) chk($sformatf("identity[%0d]", n), 32'(got[n]), 32'(ident[n]));
  endtask

  initial begin
    repeat (3) tick;
    chk("reset outputs", 32'({busy, done, in_ready, out_valid, out_last, out_data, out_index}), 0);
    reset = 1;
    tick;
    load_identity;
    run(0, 0, 0);
    chk_identity;
    set_b(1, 16'h0080);
    run(1, 0, 0);
    chk("relu index 3", 32'(got[3]), 32'h0000);
    chk("bias index 1", 32'(got[1]), 32'h0280);
    run(1, 1, 0);
    chk("gap relu index 3", 32'(got[3]), 32'h0000);
    chk("gap bias index 1", 32'(got[1]), 32'h0280);
    bp_mode = 1;
    run(0, 0, 0);
    chk("stall cycles", stall, 5);
    bp_mode = 0;
    run(0, 0, 1);
    run(0, 0, 0);
    set_b(1, 16'h0000);
    start = 1;
    tick;
    start = 0;
    feed(0);
    tick;
    tick;
    chk("busy before abort", 32'(busy), 1);
    #1 reset = 0;
    #1 chk("outputs under reset", 32'({busy, done, in_ready, out_valid, out_last, out_data, out_index}), 0);
    tick;
    tick;
    reset = 1;
    tick;
    run(0, 0, 0);
    chk_identity;
    for (int n = 0; n < 6; n++) for (int i = 0; i < 4; i++) set_w(n, i, 16'h7FFF);
    X = '{default: 16'h7FFF};
    run(0, 0, 0);
    for (int n = 0; n < 6; n++) chk($sformatf("sat pos[%0d]", n), 32'(got[n]), 32'h7FFF);
    X = '{default: 16'h8000};
    run(0, 0, 0);
    for (int n = 0; n < 6; n++) chk($sformatf("sat neg[%0d]", n), 32'(got[n]), 32'h8000);
    bp_mode = 2;
    repeat (3) begin
      for (int n = 0; n < 6; n++) begin
        for (int i = 0; i < 4; i++) set_w(n, i, 16'($urandom_range(0, 1023) - 512));
        set_b(n, 16'($urandom_range(0, 4095) - 2048));
      end
      for (int k = 0; k < 4; k++) X[k] = shortint'($urandom_range(0, 2047) - 1024);
      run(1'($urandom_range(0, 1)), 1, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
